data_memory: RTL and testbench

//  Data-side memory for the MIPS core: consumes data_addr/data_out/data_rd_wr from the core, returns data_in.

---
 rtl/data_memory_pkg.sv | 27 ++
 rtl/data_memory_if.sv | 26 ++
 rtl/data_mem_align.sv | 61 ++++++
 rtl/data_memory.sv | 129 ++++++++++++
 tb/tb_data_memory.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and constants for the MIPS data-side memory.
package data_memory_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } access_size_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Request fields captured at acceptance
    typedef struct packed {
        logic         rd_wr;
        access_size_t size;
        logic         sign_ext;
        logic [31:0]  addr;
        logic [31:0]  wr_data;
    } mem_req_t;

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus between the core (master) and the data memory (slave).
interface data_memory_if;
    import data_memory_pkg::*;

    logic         req_valid;
    logic         req_ready;
    logic         rd_wr;
    access_size_t access_size;
    logic         sign_ext;
    logic [31:0]  addr;
    logic [31:0]  wr_data;
    logic         resp_valid;
    logic [31:0]  rd_data;
    logic         err;

    modport master (
        output req_valid, rd_wr, access_size, sign_ext, addr, wr_data,
        input  req_ready, resp_valid, rd_data, err
    );

    modport slave (
        input  req_valid, rd_wr, access_size, sign_ext, addr, wr_data,
        output req_ready, resp_valid, rd_data, err
    );

endinterface

// File: rtl/data_mem_align.sv
// Big-endian lane steering: byte enables, store replication, load extraction/extension
// and misalignment/reserved-size detection.
module data_mem_align
    import data_memory_pkg::*;
(
    input  logic [1:0]   offset,
    input  access_size_t size,
    input  logic         sign_ext,
    input  logic [31:0]  wr_data,
    input  logic [31:0]  rd_word,
    output logic [3:0]   byte_en_c,
    output logic [31:0]  wr_word_c,
    output logic [31:0]  rd_ext_c,
    output logic         illegal_c
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Offset 0 is the most significant lane
    always_comb begin
        rd_byte = rd_word[31:24];
        case (offset)
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    assign rd_half = offset[1] ? rd_word[15:0] : rd_word[31:16];

    always_comb begin
        byte_en_c = 4'b0000;
        wr_word_c = '0;
        rd_ext_c  = '0;
        illegal_c = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byte_en_c = 4'b1000 >> offset;
                wr_word_c = {4{wr_data[7:0]}};
                rd_ext_c  = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            end
            SIZE_HALF: begin
                illegal_c = offset[0];
                byte_en_c = offset[1] ? 4'b0011 : 4'b1100;
                wr_word_c = {2{wr_data[15:0]}};
                rd_ext_c  = {{16{sign_ext & rd_half[15]}}, rd_half};
            end
            SIZE_WORD: begin
                illegal_c = (offset != 2'd0);
                byte_en_c = 4'b1111;
                wr_word_c = wr_data;
                rd_ext_c  = rd_word;
            end
            default: illegal_c = 1'b1;
        endcase
        if (illegal_c) byte_en_c = 4'b0000;
    end

endmodule

// File: rtl/data_memory.sv
// MIPS data memory: byte-addressed, big-endian word storage behind a valid/ready
// request with configurable latency and a one-cycle response pulse.
module data_memory
    import data_memory_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input logic         clk,
    input logic         reset,
    data_memory_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept, access;
    mem_req_t         req_q;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      offs;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic             bad;

    logic [3:0]       byte_en_c;
    logic [31:0]      wr_word_c;
    logic [31:0]      rd_ext_c;
    logic             illegal_c;

    logic             req_ready_q;
    logic             resp_valid_q;
    logic [31:0]      rd_data_q;
    logic             err_q;

    assign offs     = req_q.addr - BASE_ADDR;
    assign in_range = (offs < SPAN);
    assign idx      = offs[IDX_W+1:2];
    assign rd_word  = mem[idx];
    assign bad      = illegal_c | ~in_range;

    data_mem_align u_align (
        .offset    (req_q.addr[1:0]),
        .size      (req_q.size),
        .sign_ext  (req_q.sign_ext),
        .wr_data   (req_q.wr_data),
        .rd_word   (rd_word),
        .byte_en_c (byte_en_c),
        .wr_word_c (wr_word_c),
        .rd_ext_c  (rd_ext_c),
        .illegal_c (illegal_c)
    );

    // Next-state: IDLE/RESP accept, BUSY counts down then performs the access
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = ST_BUSY;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    access     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            req_ready_q  <= (state_next != ST_BUSY);
            resp_valid_q <= (state_next == ST_RESP);
            if (accept) begin
                req_q.rd_wr    <= bus.rd_wr;
                req_q.size     <= bus.access_size;
                req_q.sign_ext <= bus.sign_ext;
                req_q.addr     <= bus.addr;
                req_q.wr_data  <= bus.wr_data;
            end
            if (access) begin
                err_q <= bad;
                if (req_q.rd_wr == MEM_READ) rd_data_q <= bad ? 32'h0 : rd_ext_c;
            end
        end
    end

    // Storage is not reset; reset forces IDLE so an aborted store never commits
    always_ff @(posedge clk) begin
        if (access && (req_q.rd_wr == MEM_WRITE) && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_c[i]) mem[idx][8*i +: 8] <= wr_word_c[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: one LATENCY=1 instance and one LATENCY=3 instance.
module tb_data_memory;
    import data_memory_pkg::*;

    logic clk = 1'b0;
    logic reset1, reset3;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    data_memory_if b1();
    data_memory_if b3();

    data_memory #(.BASE_ADDR(32'h8002_0000), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset1), .bus(b1));
    data_memory #(.BASE_ADDR(32'h8002_0000), .DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset3), .bus(b3));

    task automatic set_req(input bit sel, input logic v, input logic rw, input logic [1:0] size,
                           input logic sx, input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            b3.req_valid = v; b3.rd_wr = rw; b3.access_size = access_size_t'(size);
            b3.sign_ext = sx; b3.addr = a; b3.wr_data = wd;
        end else begin
            b1.req_valid = v; b1.rd_wr = rw; b1.access_size = access_size_t'(size);
            b1.sign_ext = sx; b1.addr = a; b1.wr_data = wd;
        end
    endtask

    // One request; lat = rising edges after acceptance until resp_valid is seen (20 = timeout)
    task automatic xact(input bit sel, input logic rw, input logic [1:0] size, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        set_req(sel, 1'b1, rw, size, sx, a, wd);
        @(posedge clk);
        #1 set_req(sel, 1'b0, rw, size, sx, a, wd);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if ((sel ? b3.resp_valid : b1.resp_valid) === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        rd = sel ? b3.rd_data : b1.rd_data;
        e  = sel ? b3.err : b1.err;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic e; int lat; int n;
        tests++; if (b1.req_ready !== 1'b1 || b1.resp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_init got ready=%b resp=%b exp ready=1 resp=0", b1.req_ready, b1.resp_valid); end
        xact(0, MEM_WRITE, 2'd2, 1'b0, 32'h8002_0010, 32'h1234_5678, rd, e, lat);
        xact(0, MEM_READ, 2'd2, 1'b0, 32'h8002_0010, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h1234_5678) begin
            fails++; $display("FAIL reset_preload got=%h exp=12345678", rd); end
        xact(0, MEM_WRITE, 2'd2, 1'b0, 32'h8002_0012, 32'h0, rd, e, lat);
        tests++; if (e !== 1'b1 || rd !== 32'h1234_5678) begin
            fails++; $display("FAIL reset_errstore got err=%b rd=%h exp err=1 rd=12345678", e, rd); end
        @(negedge clk);
        set_req(0, 1'b1, MEM_READ, 2'd2, 1'b0, 32'h8002_0010, 32'h0);
        @(posedge clk);
        #1 set_req(0, 1'b0, MEM_READ, 2'd2, 1'b0, 32'h8002_0010, 32'h0);
        #2 reset1 = 1'b1;
        #1;
        tests++; if (b1.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", b1.req_ready); end
        tests++; if (b1.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp got=%b exp=0", b1.resp_valid); end
        tests++; if (b1.rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got=%h exp=00000000", b1.rd_data); end
        tests++; if (b1.err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", b1.err); end
        @(negedge clk); reset1 = 1'b0;
        n = 0;
        repeat (3) begin @(negedge clk); if (b1.resp_valid === 1'b1) n++; end
        tests++; if (n != 0) begin fails++; $display("FAIL reset_no_resp got=%0d pulses exp=0", n); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat;
        xact(0, MEM_WRITE, 2'd2, 1'b0, 32'h8002_0004, 32'hDEAD_BEEF, rd, e, lat);
        tests++; if (e !== 1'b0 || lat != 1) begin
            fails++; $display("FAIL word_store got err=%b lat=%0d exp err=0 lat=1", e, lat); end
        xact(0, MEM_READ, 2'd2, 1'b0, 32'h8002_0004, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0 || lat != 1) begin
            fails++; $display("FAIL word_load got rd=%h err=%b lat=%0d exp rd=deadbeef err=0 lat=1", rd, e, lat); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic e; int lat;
        logic [31:0] va [7] = '{32'h8002_0005, 32'h8002_0005, 32'h8002_0006, 32'h8002_0004,
                                32'h8002_0004, 32'h8002_0007, 32'h8002_0006};
        logic [1:0]  vs [7] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        logic        vx [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ve [7] = '{32'hFFFF_FFAD, 32'h0000_00AD, 32'hFFFF_BEEF, 32'h0000_00DE,
                                32'h0000_DEAD, 32'hFFFF_FFEF, 32'h0000_BEEF};
        for (int i = 0; i < 7; i++) begin
            xact(0, MEM_READ, vs[i], vx[i], va[i], 32'h0, rd, e, lat);
            tests++; if (rd !== ve[i] || e !== 1'b0) begin
                fails++; $display("FAIL subword_load[%0d] got rd=%h err=%b exp rd=%h err=0", i, rd, e, ve[i]); end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic e; int lat;
        xact(0, MEM_WRITE, 2'd0, 1'b0, 32'h8002_0007, 32'hFFFF_FF12, rd, e, lat);
        tests++; if (e !== 1'b0 || rd !== 32'h0000_BEEF) begin
            fails++; $display("FAIL byte_store got err=%b rd=%h exp err=0 rd=0000beef", e, rd); end
        xact(0, MEM_READ, 2'd2, 1'b0, 32'h8002_0004, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'hDEAD_BE12) begin
            fails++; $display("FAIL byte_store_load got=%h exp=deadbe12", rd); end
        xact(0, MEM_WRITE, 2'd1, 1'b0, 32'h8002_0004, 32'h1234_CAFE, rd, e, lat);
        xact(0, MEM_READ, 2'd2, 1'b0, 32'h8002_0004, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'hCAFE_BE12) begin
            fails++; $display("FAIL half_store_load got=%h exp=cafebe12", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        logic [31:0] la [5] = '{32'h8002_0002, 32'h8002_0001, 32'h8001_FFFC, 32'h8002_0004, 32'h8002_1000};
        logic [1:0]  ls [5] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] sa [4] = '{32'h8002_0006, 32'h8002_1004, 32'h8002_0005, 32'h8002_0004};
        logic [1:0]  ss [4] = '{2'd2, 2'd2, 2'd1, 2'd3};
        for (int i = 0; i < 5; i++) begin
            xact(0, MEM_READ, ls[i], 1'b1, la[i], 32'h0, rd, e, lat);
            tests++; if (e !== 1'b1 || rd !== 32'h0) begin
                fails++; $display("FAIL err_load[%0d] got err=%b rd=%h exp err=1 rd=00000000", i, e, rd); end
        end
        for (int i = 0; i < 4; i++) begin
            xact(0, MEM_WRITE, ss[i], 1'b0, sa[i], 32'h1111_1111, rd, e, lat);
            tests++; if (e !== 1'b1) begin
                fails++; $display("FAIL err_store[%0d] got err=%b exp err=1", i, e); end
        end
        xact(0, MEM_READ, 2'd2, 1'b0, 32'h8002_0004, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'hCAFE_BE12 || e !== 1'b0) begin
            fails++; $display("FAIL err_mem_unchanged got rd=%h err=%b exp rd=cafebe12 err=0", rd, e); end
        xact(0, MEM_WRITE, 2'd2, 1'b0, 32'h8002_0FFC, 32'h0BAD_F00D, rd, e, lat);
        xact(0, MEM_READ, 2'd2, 1'b0, 32'h8002_0FFC, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'h0BAD_F00D || e !== 1'b0) begin
            fails++; $display("FAIL last_word got rd=%h err=%b exp rd=0badf00d err=0", rd, e); end
    endtask

    task automatic test_latency3();
        logic [31:0] rd; logic e; int lat;
        logic [11:0] resp_mask, ready_mask;
        xact(1, MEM_WRITE, 2'd2, 1'b0, 32'h8002_0000, 32'hA5A5_A5A5, rd, e, lat);
        tests++; if (e !== 1'b0 || lat != 3) begin
            fails++; $display("FAIL lat3_store got err=%b lat=%0d exp err=0 lat=3", e, lat); end
        xact(1, MEM_READ, 2'd2, 1'b0, 32'h8002_0000, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'hA5A5_A5A5 || lat != 3) begin
            fails++; $display("FAIL lat3_load got rd=%h lat=%0d exp rd=a5a5a5a5 lat=3", rd, lat); end
        @(negedge clk);
        set_req(1, 1'b1, MEM_READ, 2'd0, 1'b0, 32'h8002_0001, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            resp_mask[k]  = b3.resp_valid;
            ready_mask[k] = b3.req_ready;
            if (k == 11) set_req(1, 1'b0, MEM_READ, 2'd0, 1'b0, 32'h8002_0001, 32'h0);
        end
        tests++; if (resp_mask !== 12'b1000_1000_1000) begin
            fails++; $display("FAIL b2b_resp got=%b exp=100010001000", resp_mask); end
        tests++; if (ready_mask !== 12'b1000_1000_1000) begin
            fails++; $display("FAIL b2b_ready got=%b exp=100010001000", ready_mask); end
        tests++; if (b3.rd_data !== 32'h0000_00A5) begin
            fails++; $display("FAIL b2b_rd_data got=%h exp=000000a5", b3.rd_data); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic e; int lat; int n;
        @(negedge clk);
        set_req(1, 1'b1, MEM_WRITE, 2'd2, 1'b0, 32'h8002_0000, 32'h5A5A_5A5A);
        @(posedge clk);
        #1 set_req(1, 1'b0, MEM_WRITE, 2'd2, 1'b0, 32'h8002_0000, 32'h5A5A_5A5A);
        @(posedge clk);
        #2 reset3 = 1'b1;
        #1;
        tests++; if (b3.req_ready !== 1'b1 || b3.rd_data !== 32'h0) begin
            fails++; $display("FAIL abort_reset got ready=%b rd=%h exp ready=1 rd=00000000", b3.req_ready, b3.rd_data); end
        @(negedge clk); reset3 = 1'b0;
        n = 0;
        repeat (6) begin @(negedge clk); if (b3.resp_valid === 1'b1) n++; end
        tests++; if (n != 0) begin fails++; $display("FAIL abort_no_resp got=%0d pulses exp=0", n); end
        xact(1, MEM_READ, 2'd2, 1'b0, 32'h8002_0000, 32'h0, rd, e, lat);
        tests++; if (rd !== 32'hA5A5_A5A5 || e !== 1'b0) begin
            fails++; $display("FAIL abort_old_value got rd=%h err=%b exp rd=a5a5a5a5 err=0", rd, e); end
    endtask

    initial begin
        reset1 = 1'b1;
        reset3 = 1'b1;
        set_req(0, 1'b0, MEM_READ, 2'd2, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, MEM_READ, 2'd2, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        reset1 = 1'b0;
        reset3 = 1'b0;
        @(negedge clk);
        test_reset();
        test_word();
        test_subword();
        test_byte_store();
        test_errors();
        test_latency3();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
